// File: rtl/alarm_mode_ctrl.sv
// Alarm clock mode controller: per-button rising-edge detection, press arbitration,
// and run/adjust sequencing with inc/dec/alarm_stop pulses and an inactivity timeout.
module alarm_mode_ctrl #(
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_c,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       tick_1hz,
    input  logic       alarm_ring,
    output logic       clk_en,
    output logic       adjust,
    output logic [1:0] sel,
    output logic       inc,
    output logic       dec,
    output logic       alarm_stop,
    output logic [4:0] mode_led
);

    localparam int TW = $clog2(TIMEOUT_S + 1);

    typedef enum logic [1:0] {
        ED_IDLE,
        ED_PULSE,
        ED_HELD
    } ed_state_t;

    typedef enum logic [2:0] {
        CLOCK,
        ADJ_HOUR,
        ADJ_MIN,
        ADJ_AHOUR,
        ADJ_AMIN
    } mode_t;

    // Button bit order: [0]c [1]l [2]r [3]u [4]d
    logic [4:0] btn;
    assign btn = {btn_d, btn_u, btn_r, btn_l, btn_c};

    ed_state_t ed_q [5];
    ed_state_t ed_d [5];
    logic [4:0] edge_v;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (!rst) ed_q[i] <= ED_IDLE;
            else      ed_q[i] <= ed_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            ed_d[i]   = ED_IDLE;
            edge_v[i] = (ed_q[i] == ED_PULSE);
            if (btn[i]) begin
                if (ed_q[i] == ED_IDLE) ed_d[i] = ED_PULSE;
                else                    ed_d[i] = ED_HELD;
            end
        end
    end

    // Priority c > (l xor r) > (u xor d); conflicting pairs cancel each other.
    logic any_edge, lr_act, act_c, act_l, act_r, act_u, act_d;

    always_comb begin
        any_edge = |edge_v;
        lr_act   = edge_v[1] ^ edge_v[2];
        act_c    = edge_v[0];
        act_l    = !edge_v[0] && edge_v[1] && !edge_v[2];
        act_r    = !edge_v[0] && edge_v[2] && !edge_v[1];
        act_u    = !edge_v[0] && !lr_act && edge_v[3] && !edge_v[4];
        act_d    = !edge_v[0] && !lr_act && edge_v[4] && !edge_v[3];
    end

    mode_t         state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          inc_d, dec_d, stop_d;
    logic          clk_en_d, adjust_d;
    logic [1:0]    sel_d;
    logic [4:0]    led_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= CLOCK;
            cnt_q      <= '0;
            clk_en     <= 1'b1;
            adjust     <= 1'b0;
            sel        <= 2'b00;
            inc        <= 1'b0;
            dec        <= 1'b0;
            alarm_stop <= 1'b0;
            mode_led   <= 5'b00001;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clk_en     <= clk_en_d;
            adjust     <= adjust_d;
            sel        <= sel_d;
            inc        <= inc_d;
            dec        <= dec_d;
            alarm_stop <= stop_d;
            mode_led   <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        stop_d  = 1'b0;
        if (state_q == CLOCK) begin
            cnt_d = '0;
            if (alarm_ring)  stop_d  = any_edge;
            else if (act_c)  state_d = ADJ_HOUR;
        end else if (any_edge) begin
            // A button edge always restarts the inactivity window, even one that loses arbitration.
            cnt_d = '0;
            if (act_c) begin
                state_d = CLOCK;
            end else if (act_r) begin
                case (state_q)
                    ADJ_HOUR:  state_d = ADJ_MIN;
                    ADJ_MIN:   state_d = ADJ_AHOUR;
                    ADJ_AHOUR: state_d = ADJ_AMIN;
                    default:   state_d = ADJ_HOUR;
                endcase
            end else if (act_l) begin
                case (state_q)
                    ADJ_HOUR:  state_d = ADJ_AMIN;
                    ADJ_MIN:   state_d = ADJ_HOUR;
                    ADJ_AHOUR: state_d = ADJ_MIN;
                    default:   state_d = ADJ_AHOUR;
                endcase
            end else begin
                inc_d = act_u;
                dec_d = act_d;
            end
        end else if (tick_1hz) begin
            if (cnt_q == TW'(TIMEOUT_S - 1)) begin
                state_d = CLOCK;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + TW'(1);
            end
        end
    end

    always_comb begin
        clk_en_d = (state_d == CLOCK);
        adjust_d = (state_d != CLOCK);
        sel_d    = 2'b00;
        led_d    = 5'b00001;
        case (state_d)
            ADJ_HOUR:  begin sel_d = 2'b00; led_d = 5'b00010; end
            ADJ_MIN:   begin sel_d = 2'b01; led_d = 5'b00100; end
            ADJ_AHOUR: begin sel_d = 2'b10; led_d = 5'b01000; end
            ADJ_AMIN:  begin sel_d = 2'b11; led_d = 5'b10000; end
            default:   begin sel_d = 2'b00; led_d = 5'b00001; end
        endcase
    end

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Scoreboard bench for alarm_mode_ctrl: a cycle model predicts every output word,
// plus directed pulse-count and mode checks for the key scenarios.
module tb_alarm_mode_ctrl;

    localparam int TO = 3;
    localparam logic [4:0] BC = 5'b00001, BL = 5'b00010, BR = 5'b00100,
                           BU = 5'b01000, BD = 5'b10000, BN = 5'b00000;

    logic clk = 1'b0;
    logic rst, btn_c, btn_l, btn_r, btn_u, btn_d, tick_1hz, alarm_ring;
    logic clk_en, adjust, inc, dec, alarm_stop;
    logic [1:0] sel;
    logic [4:0] mode_led;

    always #5 clk = ~clk;

    alarm_mode_ctrl #(.TIMEOUT_S(TO)) dut (
        .clk(clk), .rst(rst), .btn_c(btn_c), .btn_l(btn_l), .btn_r(btn_r),
        .btn_u(btn_u), .btn_d(btn_d), .tick_1hz(tick_1hz), .alarm_ring(alarm_ring),
        .clk_en(clk_en), .adjust(adjust), .sel(sel), .inc(inc), .dec(dec),
        .alarm_stop(alarm_stop), .mode_led(mode_led)
    );

    // Word layout: {clk_en, adjust, sel[1:0], inc, dec, alarm_stop, mode_led[4:0]}
    logic [11:0] sb [$];
    logic [11:0] expWord, obsWord, lastOut;
    int compared = 0, mismatched = 0, cyc = 0;
    int incCount = 0, decCount = 0, stopCount = 0;

    int         mState = 0, mCnt = 0;
    logic [4:0] pend = '0, prevHigh = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [4:0] b, input logic t, input logic ring);
        logic pInc, pDec, pStop;
        logic [1:0] pSel;
        @(negedge clk);
        rst = r;
        {btn_d, btn_u, btn_r, btn_l, btn_c} = b;
        tick_1hz = t;
        alarm_ring = ring;
        pInc = 1'b0; pDec = 1'b0; pStop = 1'b0;
        if (!r) begin
            mState = 0; mCnt = 0; pend = '0; prevHigh = '0;
        end else begin
            if (mState == 0) begin
                mCnt = 0;
                if (ring) pStop = (pend != 0);
                else if (pend[0]) mState = 1;
            end else if (pend != 0) begin
                mCnt = 0;
                if (pend[0]) mState = 0;
                else if (pend[1] != pend[2]) mState = pend[2] ? (mState % 4) + 1 : ((mState + 2) % 4) + 1;
                else if (pend[3] != pend[4]) begin pInc = pend[3]; pDec = pend[4]; end
            end else if (t) begin
                mCnt++;
                if (mCnt == TO) begin mState = 0; mCnt = 0; end
            end
            pend = b & ~prevHigh;
            prevHigh = b;
        end
        pSel = (mState == 0) ? 2'b00 : 2'(mState - 1);
        sb.push_back({(mState == 0), (mState != 0), pSel, pInc, pDec, pStop, 5'(1 << mState)});
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input logic ring);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, BN, 1'b0, ring);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                expWord = sb.pop_front();
                obsWord = {clk_en, adjust, sel, inc, dec, alarm_stop, mode_led};
                checkOutput($sformatf("cycle %0d outputs", cyc), 32'(obsWord), 32'(expWord));
                lastOut = obsWord;
                if (inc === 1'b1) incCount++;
                if (dec === 1'b1) decCount++;
                if (alarm_stop === 1'b1) stopCount++;
                cyc++;
            end
        end
    end

    initial begin
        logic [1:0] selSeq [4];
        logic [4:0] rb;
        logic rring;
        selSeq = '{2'b01, 2'b10, 2'b11, 2'b00};
        rst = 1'b0; {btn_d, btn_u, btn_r, btn_l, btn_c} = '0; tick_1hz = 1'b0; alarm_ring = 1'b0;

        // 1: reset, single-cycle centre press enters hour adjust
        applyStimulus(1'b0, BN, 1'b0, 1'b0);
        checkOutput("reset word", 32'(lastOut), 32'(12'b1000_0000_0001));
        applyStimulus(1'b0, BN, 1'b0, 1'b0);
        idle(2, 1'b0);
        applyStimulus(1'b1, BC, 1'b0, 1'b0);
        idle(3, 1'b0);
        checkOutput("t1 mode_led", 32'(lastOut[4:0]), 32'(5'b00010));
        checkOutput("t1 clk_en", 32'(lastOut[11]), 32'd0);
        checkOutput("t1 inc+dec", 32'(incCount + decCount), 32'd0);

        // 2: long up hold gives one inc; right cycles through fields
        incCount = 0;
        repeat (20) applyStimulus(1'b1, BU, 1'b0, 1'b0);
        idle(2, 1'b0);
        checkOutput("t2 inc count", 32'(incCount), 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, BR, 1'b0, 1'b0);
            idle(2, 1'b0);
            checkOutput($sformatf("t2 sel step %0d", i), 32'(lastOut[9:8]), 32'(selSeq[i]));
        end

        // 3: up+down cancel; centre beats up
        applyStimulus(1'b1, BR, 1'b0, 1'b0);
        idle(2, 1'b0);
        incCount = 0; decCount = 0;
        applyStimulus(1'b1, BU | BD, 1'b0, 1'b0);
        idle(2, 1'b0);
        checkOutput("t3 u&d pulses", 32'(incCount + decCount), 32'd0);
        applyStimulus(1'b1, BC | BU, 1'b0, 1'b0);
        idle(2, 1'b0);
        checkOutput("t3 c&u inc", 32'(incCount), 32'd0);
        checkOutput("t3 c&u mode_led", 32'(lastOut[4:0]), 32'(5'b00001));

        // 4: any press while ringing only silences the alarm
        stopCount = 0;
        idle(1, 1'b1);
        applyStimulus(1'b1, BL, 1'b0, 1'b1);
        idle(3, 1'b1);
        checkOutput("t4 stop count", 32'(stopCount), 32'd1);
        checkOutput("t4 mode_led", 32'(lastOut[4:0]), 32'(5'b00001));
        idle(2, 1'b0);

        // 5: timeout after TO ticks; edge coinciding with a tick restarts the count
        applyStimulus(1'b1, BC, 1'b0, 1'b0);
        idle(2, 1'b0);
        for (int i = 0; i < TO; i++) begin
            applyStimulus(1'b1, BN, 1'b1, 1'b0);
            idle(1, 1'b0);
        end
        checkOutput("t5 timeout mode_led", 32'(lastOut[4:0]), 32'(5'b00001));
        applyStimulus(1'b1, BC, 1'b0, 1'b0);
        idle(2, 1'b0);
        decCount = 0;
        applyStimulus(1'b1, BN, 1'b1, 1'b0);
        applyStimulus(1'b1, BD, 1'b0, 1'b0);
        applyStimulus(1'b1, BN, 1'b1, 1'b0);
        idle(1, 1'b0);
        checkOutput("t5 dec count", 32'(decCount), 32'd1);
        for (int i = 0; i < TO - 1; i++) begin
            applyStimulus(1'b1, BN, 1'b1, 1'b0);
            idle(1, 1'b0);
        end
        checkOutput("t5 still adjusting", 32'(lastOut[4:0]), 32'(5'b00010));
        applyStimulus(1'b1, BN, 1'b1, 1'b0);
        idle(1, 1'b0);
        checkOutput("t5 restarted timeout", 32'(lastOut[4:0]), 32'(5'b00001));

        // 6: reset in alarm-minute adjust with up held
        applyStimulus(1'b1, BC, 1'b0, 1'b0);
        idle(1, 1'b0);
        applyStimulus(1'b1, BL, 1'b0, 1'b0);
        idle(2, 1'b0);
        checkOutput("t6 amin mode_led", 32'(lastOut[4:0]), 32'(5'b10000));
        repeat (3) applyStimulus(1'b1, BU, 1'b0, 1'b0);
        applyStimulus(1'b0, BU, 1'b0, 1'b0);
        checkOutput("t6 reset clk_en", 32'(lastOut[11]), 32'd1);
        incCount = 0;
        repeat (5) applyStimulus(1'b1, BU, 1'b0, 1'b0);
        idle(2, 1'b0);
        checkOutput("t6 inc after reset", 32'(incCount), 32'd0);
        checkOutput("t6 mode_led", 32'(lastOut[4:0]), 32'(5'b00001));

        // Random traffic, every cycle checked against the model
        rb = '0; rring = 1'b0;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 5; k++) if ($urandom_range(0, 5) == 0) rb[k] = ~rb[k];
            if ($urandom_range(0, 15) == 0) rring = ~rring;
            applyStimulus(($urandom_range(0, 60) != 0), rb, ($urandom_range(0, 3) == 0), rring);
        end
        idle(2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
